// File: rtl/seq_calc_param.sv
// seq_calc_param: two-term recurrence generator with RAM capture.
//
// Produces term[k] = f(term[k-1], term[k-2]) from two seeds. Every generated
// term is written into an internal RAM at address k. The RAM has a registered
// read port. A gate-level ripple adder/subtractor runs beside the behavioural
// operator. Any disagreement between the two sets a sticky mismatch flag.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   en        advance enable; low stalls the run without losing state
//   start     start request, honoured only when busy=0
//   mode      00 add mod 2^W, 01 sub, 10 xor, 11 saturating add
//   seed0/1   term[0] / term[1], captured on an accepted start
//   len       number of terms to generate (clamped to DEPTH)
//   rd_addr   RAM read address
//   rd_data   ram[rd_addr], one-cycle latency
//   busy      high while running
//   done      one-cycle pulse after the last write
//   term      last term written
//   count     terms written in the current/last run
//   overflow  sticky per run: carry (00), borrow (01), clamp (11)
//   mismatch  sticky: structural result != behavioural result
module seq_calc_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  seed0,
  input  logic [WIDTH-1:0]  seed1,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  term,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              mismatch
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   seed0_q, seed0_d, seed1_q, seed1_d;
  logic [ADDR_W:0]    len_q, len_d, len_clamp;
  logic [WIDTH-1:0]   r1_q, r1_d, r2_q, r2_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               ovf_q, ovf_d, mis_q, mis_d;
  logic [WIDTH-1:0]   rd_data_q;
  logic               we;
  logic [WIDTH-1:0]   t;
  logic               past_seeds;

  logic [WIDTH-1:0]   mem [DEPTH];

  // Behavioural operator
  logic [WIDTH:0]     add_full, sub_full;
  logic [WIDTH-1:0]   f_res;
  logic               f_ovf;

  assign add_full = {1'b0, r1_q} + {1'b0, r2_q};
  assign sub_full = {1'b0, r1_q} - {1'b0, r2_q};

  always_comb begin
    f_res = '0;
    f_ovf = 1'b0;
    unique case (mode_q)
      2'b00: begin
        f_res = add_full[WIDTH-1:0];
        f_ovf = add_full[WIDTH];
      end
      2'b01: begin
        f_res = sub_full[WIDTH-1:0];
        f_ovf = sub_full[WIDTH];
      end
      2'b10: f_res = r1_q ^ r2_q;
      2'b11: begin
        f_res = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
        f_ovf = add_full[WIDTH];
      end
      default: ;
    endcase
  end

  // Structural ripple datapath: subtraction as r1 + ~r2 + 1
  logic             sub_op;
  logic [WIDTH-1:0] rip_b, rip_s, rip_res;
  logic [WIDTH:0]   rip_c;

  assign sub_op   = (mode_q == 2'b01);
  assign rip_b    = r2_q ^ {WIDTH{sub_op}};
  assign rip_c[0] = sub_op;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign rip_s[i]   = r1_q[i] ^ rip_b[i] ^ rip_c[i];
    assign rip_c[i+1] = (r1_q[i] & rip_b[i]) | (rip_c[i] & (r1_q[i] ^ rip_b[i]));
  end

  always_comb begin
    rip_res = rip_s;
    unique case (mode_q)
      2'b10:   rip_res = r1_q ^ r2_q;
      2'b11:   rip_res = rip_c[WIDTH] ? {WIDTH{1'b1}} : rip_s;
      default: rip_res = rip_s;
    endcase
  end

  // Term selection: seeds first, recurrence afterwards
  assign past_seeds = |count_q[ADDR_W:1];
  assign len_clamp  = (len > DepthLen) ? DepthLen : len;

  always_comb begin
    if (count_q == '0) begin
      t = seed0_q;
    end else if (!past_seeds) begin
      t = seed1_q;
    end else begin
      t = f_res;
    end
  end

  // FSM next state and datapath updates
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    len_d   = len_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    term_d  = term_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mis_d   = mis_q;
    we      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (en) begin
          we      = 1'b1;
          term_d  = t;
          r2_d    = r1_q;
          r1_d    = t;
          count_d = count_q + 1'b1;
          if (past_seeds) begin
            ovf_d = ovf_q | f_ovf;
            mis_d = mis_q | (rip_res != f_res);
          end
          if (count_q == len_q - 1'b1) begin
            state_d = StDone;
          end
        end
      end
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (start) begin
          mode_d  = mode;
          seed0_d = seed0;
          seed1_d = seed1;
          len_d   = len_clamp;
          count_d = '0;
          ovf_d   = 1'b0;
          mis_d   = 1'b0;
          state_d = (len_clamp == '0) ? StDone : StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= '0;
      seed0_q <= '0;
      seed1_q <= '0;
      len_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      term_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed0_q <= seed0_d;
      seed1_q <= seed1_d;
      len_q   <= len_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      term_q  <= term_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mis_q   <= mis_d;
    end
  end

  // RAM contents survive reset; a write on the reset edge is dropped
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[count_q[ADDR_W-1:0]] <= t;
    end
  end

  // Read before write: same-edge read returns the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign term     = term_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign mismatch = mis_q;

endmodule

// File: tb/tb_seq_calc_param.sv
// Randomized bench for seq_calc_param with an array-based reference model.
module tb_seq_calc_param;

  localparam int W     = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;
  localparam int MAXV  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset, en, start;
  logic [1:0]    mode;
  logic [W-1:0]  seed0, seed1;
  logic [AW:0]   len;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data, term;
  logic          busy, done, overflow, mismatch;
  logic [AW:0]   count;

  seq_calc_param #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .seed0    (seed0),
    .seed1    (seed1),
    .len      (len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .term     (term),
    .count    (count),
    .overflow (overflow),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int exp_mem [DEPTH];
  int exp_cnt;
  int exp_term = 0;
  bit exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: sequence generated from the operator rules with integer math
  task automatic model_run(input int md, input int s0, input int s1, input int ln);
    int n;
    int a, b, r;
    n       = (ln > DEPTH) ? DEPTH : ln;
    exp_ovf = 0;
    r       = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        r = s0;
      end else if (k == 1) begin
        r = s1;
      end else begin
        a = exp_mem[k-1];
        b = exp_mem[k-2];
        case (md)
          0: begin r = a + b; if (r > MAXV) begin exp_ovf = 1; r -= MAXV + 1; end end
          1: begin r = a - b; if (r < 0) begin exp_ovf = 1; r += MAXV + 1; end end
          2: r = a ^ b;
          default: begin r = a + b; if (r > MAXV) begin exp_ovf = 1; r = MAXV; end end
        endcase
      end
      exp_mem[k] = r;
    end
    exp_cnt = n;
    if (n > 0) exp_term = r;
  endtask

  task automatic read_chk(input int addr, input int exp, input string tag);
    @(negedge clk);
    rd_addr = addr[AW-1:0];
    @(negedge clk);
    check_eq(tag, rd_data, exp);
  endtask

  // Runs one sequence. stall_at>0 forces a 3-cycle en=0 window at that cycle;
  // otherwise stall_pct gives random stalls. poke fires start while busy.
  task automatic run_seq(input int md, input int s0, input int s1, input int ln,
                         input int stall_pct, input int stall_at, input bit poke);
    int  cyc;
    int  stalls = 0;
    bit  got_done = 0;
    bit  busy_drop = 0;
    int  frozen = 0;
    model_run(md, s0, s1, ln);
    @(negedge clk);
    mode  = md[1:0];
    seed0 = s0[W-1:0];
    seed1 = s1[W-1:0];
    len   = ln[AW:0];
    start = 1'b1;
    en    = 1'b1;
    for (cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1;
        break;
      end
      if (!busy) busy_drop = 1;
      if (stall_at > 0) begin
        if (cyc == stall_at) frozen = int'(count);
        en = (cyc >= stall_at && cyc < stall_at + 3) ? 1'b0 : 1'b1;
        if (cyc == stall_at + 3) check_eq("count_frozen", count, frozen);
      end else begin
        en = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      end
      if (!en) stalls++;
      if (poke && $urandom_range(5) == 0) begin
        start = 1'b1;
        mode  = 2'($urandom);
        seed0 = W'($urandom);
        seed1 = W'($urandom);
        len   = (AW+1)'($urandom);
      end
    end
    en = 1'b1;
    check_eq("done_seen", got_done, 1);
    check_eq("busy_held", busy_drop, 0);
    if (got_done) begin
      check_eq("done_cycle", cyc, exp_cnt + 1 + stalls);
      check_eq("busy_at_done", busy, 0);
      check_eq("count", count, exp_cnt);
      check_eq("term", term, exp_term);
      check_eq("overflow", overflow, exp_ovf);
      check_eq("mismatch", mismatch, 0);
      @(negedge clk);
      check_eq("done_pulse", done, 0);
      if (exp_cnt <= 48) begin
        for (int k = 0; k < exp_cnt; k++) read_chk(k, exp_mem[k], "ram");
      end else begin
        for (int k = 0; k < 16; k++) begin
          int a;
          a = $urandom_range(exp_cnt - 1);
          read_chk(a, exp_mem[a], "ram_rand");
        end
        read_chk(exp_cnt - 1, exp_mem[exp_cnt-1], "ram_last");
      end
    end
  endtask

  task automatic reset_mid_run();
    bit hit = 0;
    model_run(0, 1, 2, 20);
    @(negedge clk);
    mode = 2'b00; seed0 = 8'd1; seed1 = 8'd2; len = 20; start = 1'b1; en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (count == 5) begin
        hit = 1;
        break;
      end
    end
    check_eq("reach_count5", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_term", term, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_mis", mismatch, 0);
    check_eq("rst_rd", rd_data, 0);
    reset = 1'b0;
    exp_term = 0;
    @(negedge clk);
    check_eq("rst_no_done", done, 0);
    for (int k = 0; k < 5; k++) read_chk(k, exp_mem[k], "ram_kept");
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; start = 1'b0; mode = '0;
    seed0 = '0; seed1 = '0; len = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_count", count, 0);
    check_eq("reset_term", term, 0);
    check_eq("reset_rd", rd_data, 0);
    reset = 1'b0;

    run_seq(0, 0, 1, 14, 0, 0, 0);
    read_chk(13, 233, "fib13");
    run_seq(0, 0, 1, 15, 0, 0, 0);
    read_chk(14, 121, "fib14_wrap");
    run_seq(3, 0, 1, 15, 0, 0, 0);
    read_chk(14, 255, "fib14_sat");
    run_seq(1, 5, 3, 4, 0, 0, 0);
    read_chk(2, 254, "sub_t2");
    read_chk(3, 251, "sub_t3");
    run_seq(2, 'hA5, 'h3C, 6, 0, 0, 0);
    read_chk(2, 'h99, "xor_t2");
    read_chk(5, 'h99, "xor_t5");
    run_seq(0, 1, 1, 10, 0, 4, 1);
    reset_mid_run();
    run_seq(1, 7, 9, 0, 0, 0, 0);
    run_seq(0, 3, 4, DEPTH + 5, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run_seq(int'($urandom_range(3)), int'($urandom_range(MAXV)),
              int'($urandom_range(MAXV)), int'($urandom_range(40)), 20, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
